// File: rtl/gift_128_ctrl_pkg.sv
// Shared types and constants for the GIFT-128 job sequencer.
package gift_128_ctrl_pkg;

   localparam int KEY_W = 128;
   localparam int BLK_W = 128;

   localparam logic OP_ENC = 1'b0;
   localparam logic OP_DEC = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DISPATCH  = 3'd1,
      S_KEY_LD    = 3'd2,
      S_KEY_GUARD = 3'd3,
      S_KEY_WAIT  = 3'd4,
      S_START     = 3'd5,
      S_RUN       = 3'd6,
      S_RESP      = 3'd7
   } ctrl_state_e;

endpackage

// File: rtl/gift_128_ctrl_key_cache.sv
// Two-entry key cache (one per core), indexed by op; reports whether the core already holds cmp_key.
module gift_128_ctrl_key_cache
   import gift_128_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             reset,
   input  logic             idx,
   input  logic             wr_en,
   input  logic             inv_one,
   input  logic             flush,
   input  logic [KEY_W-1:0] wr_key,
   output logic             hit_o
);

   logic [1:0]            vld_q, vld_d;
   logic [1:0][KEY_W-1:0] key_q, key_d;

   // Flush overrides a same-cycle write so a racing load is never trusted.
   always_comb begin
      vld_d = vld_q;
      key_d = key_q;
      if (wr_en) begin
         vld_d[idx] = 1'b1;
         key_d[idx] = wr_key;
      end
      if (inv_one) vld_d[idx] = 1'b0;
      if (flush)   vld_d      = 2'b00;
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         vld_q <= 2'b00;
         key_q <= '0;
      end else begin
         vld_q <= vld_d;
         key_q <= key_d;
      end
   end

   assign hit_o = vld_q[idx] & (key_q[idx] == wr_key);

endmodule

// File: rtl/gift_128_ctrl.sv
// Request/response sequencer for one GIFT-128 encrypt core and one decrypt core,
// with key caching, start pulsing and per-wait timeout.
module gift_128_ctrl
   import gift_128_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 4096,
   parameter int TO_W    = 13
) (
   input  logic             clk_i,
   input  logic             reset,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_op_i,
   input  logic [KEY_W-1:0] req_key_i,
   input  logic [BLK_W-1:0] req_data_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [BLK_W-1:0] rsp_data_o,
   output logic             rsp_op_o,
   output logic             rsp_err_o,
   input  logic             key_flush_i,
   output logic             busy_o,
   output logic [KEY_W-1:0] enc_key_o,
   output logic [KEY_W-1:0] dec_key_o,
   output logic             enc_key_ld_o,
   output logic             dec_key_ld_o,
   input  logic             enc_key_done_i,
   input  logic             dec_key_done_i,
   output logic [BLK_W-1:0] enc_data_o,
   output logic [BLK_W-1:0] dec_data_o,
   output logic             enc_start_o,
   output logic             dec_start_o,
   input  logic [BLK_W-1:0] enc_result_i,
   input  logic [BLK_W-1:0] dec_result_i,
   input  logic             enc_done_i,
   input  logic             dec_done_i
);

   ctrl_state_e      state_q, state_d;
   logic             op_q, op_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [BLK_W-1:0] data_q, data_d;
   logic [TO_W-1:0]  cnt_q, cnt_d;
   logic [BLK_W-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_op_q, rsp_op_d, rsp_err_q, rsp_err_d;
   logic             rsp_valid_q, rsp_valid_d, req_ready_q, req_ready_d, busy_q, busy_d;
   logic             enc_key_ld_q, enc_key_ld_d, dec_key_ld_q, dec_key_ld_d;
   logic             enc_start_q, enc_start_d, dec_start_q, dec_start_d;

   logic             cache_hit, cache_wr, cache_inv;
   logic             sel_key_done, sel_done, expire;
   logic [BLK_W-1:0] sel_result;

   gift_128_ctrl_key_cache u_key_cache (
      .clk_i   (clk_i),
      .reset   (reset),
      .idx     (op_q),
      .wr_en   (cache_wr),
      .inv_one (cache_inv),
      .flush   (key_flush_i),
      .wr_key  (key_q),
      .hit_o   (cache_hit)
   );

   assign sel_key_done = (op_q == OP_DEC) ? dec_key_done_i : enc_key_done_i;
   assign sel_done     = (op_q == OP_DEC) ? dec_done_i     : enc_done_i;
   assign sel_result   = (op_q == OP_DEC) ? dec_result_i   : enc_result_i;
   assign expire       = (cnt_q == TO_W'(TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      key_d      = key_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_op_d   = rsp_op_q;
      rsp_err_d  = rsp_err_q;
      cache_wr   = 1'b0;
      cache_inv  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               op_d    = req_op_i;
               key_d   = req_key_i;
               data_d  = req_data_i;
               state_d = S_DISPATCH;
            end
         end
         S_DISPATCH: state_d = (cache_hit & ~key_flush_i) ? S_START : S_KEY_LD;
         S_KEY_LD: begin
            cache_inv = 1'b1;
            state_d   = S_KEY_GUARD;
         end
         // The core clears its key-done latch during this cycle, so it is not looked at.
         S_KEY_GUARD: begin
            cnt_d   = '0;
            state_d = S_KEY_WAIT;
         end
         S_KEY_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (sel_key_done) begin
               cache_wr = 1'b1;
               state_d  = S_START;
            end else if (expire) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               rsp_op_d   = op_q;
               state_d    = S_RESP;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (sel_done) begin
               rsp_data_d = sel_result;
               rsp_err_d  = 1'b0;
               rsp_op_d   = op_q;
               state_d    = S_RESP;
            end else if (expire) begin
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               rsp_op_d   = op_q;
               cache_inv  = 1'b1;
               state_d    = S_RESP;
            end
         end
         S_RESP: if (rsp_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so every port comes straight off a flop.
      req_ready_d  = (state_d == S_IDLE);
      busy_d       = (state_d != S_IDLE);
      rsp_valid_d  = (state_d == S_RESP);
      enc_key_ld_d = (state_d == S_KEY_LD) & (op_q == OP_ENC);
      dec_key_ld_d = (state_d == S_KEY_LD) & (op_q == OP_DEC);
      enc_start_d  = (state_d == S_START)  & (op_q == OP_ENC);
      dec_start_d  = (state_d == S_START)  & (op_q == OP_DEC);
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q      <= S_IDLE;
         op_q         <= OP_ENC;
         key_q        <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
         rsp_data_q   <= '0;
         rsp_op_q     <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_valid_q  <= 1'b0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         enc_key_ld_q <= 1'b0;
         dec_key_ld_q <= 1'b0;
         enc_start_q  <= 1'b0;
         dec_start_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         key_q        <= key_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         rsp_data_q   <= rsp_data_d;
         rsp_op_q     <= rsp_op_d;
         rsp_err_q    <= rsp_err_d;
         rsp_valid_q  <= rsp_valid_d;
         req_ready_q  <= req_ready_d;
         busy_q       <= busy_d;
         enc_key_ld_q <= enc_key_ld_d;
         dec_key_ld_q <= dec_key_ld_d;
         enc_start_q  <= enc_start_d;
         dec_start_q  <= dec_start_d;
      end
   end

   assign req_ready_o  = req_ready_q;
   assign busy_o       = busy_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_data_o   = rsp_data_q;
   assign rsp_op_o     = rsp_op_q;
   assign rsp_err_o    = rsp_err_q;
   assign enc_key_o    = key_q;
   assign dec_key_o    = key_q;
   assign enc_data_o   = data_q;
   assign dec_data_o   = data_q;
   assign enc_key_ld_o = enc_key_ld_q;
   assign dec_key_ld_o = dec_key_ld_q;
   assign enc_start_o  = enc_start_q;
   assign dec_start_o  = dec_start_q;

endmodule
